// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Optional flush port enabled by defining MD_CANCEL_EN.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
`ifdef MD_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DFIX
  } state_t;

  state_t stateQ;
  state_t stateD;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] origA;
  logic [WIDTH-1:0] rem;
  logic             isSigned;
  logic             negQ;
  logic             negR;
  logic             cancelHit;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [2*WIDTH-1:0] aExt;
  logic [2*WIDTH-1:0] bExt;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               qBit;
  logic [WIDTH-1:0]   remNext;

`ifdef MD_CANCEL_EN
  assign cancelHit = cancel;
`else
  assign cancelHit = 1'b0;
`endif

  assign busy = (stateQ != IDLE);

  // Operand magnitudes for signed divide
  assign absA = (md_op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
  assign absB = (md_op[0] && src_b[WIDTH-1]) ? -src_b : src_b;

  // Full-width product; extension makes one multiplier serve both signednesses
  assign aExt    = {{WIDTH{isSigned & opA[WIDTH-1]}}, opA};
  assign bExt    = {{WIDTH{isSigned & opB[WIDTH-1]}}, opB};
  assign product = aExt * bExt;

  // One restoring division step; opA doubles as the quotient shift register
  assign shifted = {rem, opA[WIDTH-1]};
  assign diff    = shifted - {1'b0, opB};
  assign qBit    = ~diff[WIDTH];
  assign remNext = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: begin
        if (start) stateD = md_op[1] ? DIV : MUL;
      end
      MUL: begin
        if (cancelHit || cnt == '0) stateD = IDLE;
      end
      DIV: begin
        if (cancelHit)      stateD = IDLE;
        else if (cnt == '0) stateD = DFIX;
      end
      DFIX: begin
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  // Operand latching, iteration datapath and HI/LO update
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      opA      <= '0;
      opB      <= '0;
      origA    <= '0;
      rem      <= '0;
      isSigned <= 1'b0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      unique case (stateQ)
        IDLE: begin
          if (start) begin
            isSigned <= md_op[0];
            origA    <= src_a;
            if (!md_op[1]) begin
              opA <= src_a;
              opB <= src_b;
              cnt <= CW'(MUL_CYCLES - 1);
            end else begin
              opA  <= absA;
              opB  <= absB;
              rem  <= '0;
              negQ <= md_op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              negR <= md_op[0] & src_a[WIDTH-1];
              cnt  <= CW'(WIDTH - 1);
            end
          end else if (hilo_we) begin
            if (hilo_sel) hi <= src_a;
            else          lo <= src_a;
          end
        end
        MUL: begin
          if (!cancelHit) begin
            if (cnt == '0) {hi, lo} <= product;
            else           cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          if (!cancelHit) begin
            rem <= remNext;
            opA <= {opA[WIDTH-2:0], qBit};
            if (cnt != '0) cnt <= cnt - CW'(1);
          end
        end
        DFIX: begin
          if (!cancelHit) begin
            if (opB == '0) begin
              lo <= '1;
              hi <= origA;
            end else begin
              lo <= negQ ? -opA : opA;
              hi <= negR ? -rem : rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit multiply, divide and HI/LO.
// Covers reset, latency, sign handling, div-by-zero, overflow, MTHI/MTLO.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hilo_we = 1'b0;
  logic        hilo_sel = 1'b0;
`ifdef MD_CANCEL_EN
  logic        cancel = 1'b0;
`endif
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  md_unit #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .src_a(src_a),
    .src_b(src_b),
    .hilo_we(hilo_we),
    .hilo_sel(hilo_sel),
`ifdef MD_CANCEL_EN
    .cancel(cancel),
`endif
    .busy(busy),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int expLat, input logic [31:0] expHi,
                       input logic [31:0] expLo);
    int n;
    md_op = op;
    src_a = a;
    src_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitIdle(n);
    check({tag, "_lat"}, 64'(n), 64'(expLat));
    check({tag, "_hi"}, 64'(hi), 64'(expHi));
    check({tag, "_lo"}, 64'(lo), 64'(expLo));
  endtask

  initial begin
    int n;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    tick();

    runOp("multu", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
          32'hFFFFFFFE, 32'h00000001);
    runOp("mult", 2'b01, 32'hFFFFFFFD, 32'd7, 5,
          32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 33,
          32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divu_z", 2'b10, 32'h12345678, 32'd0, 33,
          32'h12345678, 32'hFFFFFFFF);
    runOp("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 33,
          32'h00000000, 32'h80000000);
    runOp("div_nb", 2'b11, 32'd7, 32'hFFFFFFFE, 33,
          32'h00000001, 32'hFFFFFFFD);
    runOp("divu", 2'b10, 32'd100, 32'd7, 33,
          32'd2, 32'd14);

    // MTHI in idle
    src_a = 32'hAAAA0000;
    hilo_sel = 1'b1;
    hilo_we = 1'b1;
    tick();
    hilo_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'hAAAA0000);
    check("mthi_lo", 64'(lo), 64'd14);

    // start with hilo_we: write dropped, op performed
    md_op = 2'b00;
    src_a = 32'd3;
    src_b = 32'd5;
    hilo_sel = 1'b1;
    hilo_we = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    hilo_we = 1'b0;
    check("both_busy", 64'(busy), 64'd1);
    check("both_hi_mid", 64'(hi), 64'hAAAA0000);
    waitIdle(n);
    check("both_lat", 64'(n), 64'd5);
    check("both_hi", 64'(hi), 64'd0);
    check("both_lo", 64'(lo), 64'd15);

    // MTLO and a second start while a DIVU runs are ignored
    md_op = 2'b10;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("divu_lo_mid", 64'(lo), 64'd15);
    src_a = 32'h55;
    src_b = 32'd1;
    hilo_sel = 1'b0;
    hilo_we = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    hilo_we = 1'b0;
    check("mtlo_busy_lo", 64'(lo), 64'd15);
    waitIdle(n);
    check("mtlo_busy_lat", 64'(n), 64'd29);
    check("mtlo_busy_q", 64'(lo), 64'd14);
    check("mtlo_busy_r", 64'(hi), 64'd2);

    // Reset at cycle 10 of a DIV
    md_op = 2'b11;
    src_a = 32'hFFFFFFF9;
    src_b = 32'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("rdiv_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rdiv_busy0", 64'(busy), 64'd0);
    check("rdiv_hi", 64'(hi), 64'd0);
    check("rdiv_lo", 64'(lo), 64'd0);
    runOp("multu34", 2'b00, 32'd3, 32'd4, 5, 32'd0, 32'd12);

`ifdef MD_CANCEL_EN
    // Cancel at cycle 10 leaves HI/LO untouched
    md_op = 2'b10;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_hi", 64'(hi), 64'd0);
    check("cancel_lo", 64'(lo), 64'd12);
    runOp("post_cancel", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
          32'd0, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
